// File: rtl/uart_pkg.sv
// Shared UART definitions: default baud divider, parity encodings and the
// transmit arbiter FSM states.
package uart_pkg;

   // Divider for 115200 baud from a 1.2 GHz-class reference; reset default of the transmitter.
   localparam logic [15:0] UART_BAUD_115200_AT_1M2 = 16'd10416;

   // Parity select encodings understood by uart_tx.
   localparam logic [1:0] PARITY_NONE = 2'd0;
   localparam logic [1:0] PARITY_EVEN = 2'd1;
   localparam logic [1:0] PARITY_ODD  = 2'd2;

   // Arbiter sequencing: pick a requester, pulse send_en, wait for done, rest.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_BUSY   = 2'd2,
      ST_GAP    = 2'd3
   } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester handshake plus the uart_tx control bundle. The master side is the
// world around the arbiter (requesters and the transmitter); the slave side is
// the arbiter itself.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_ready;
   logic [15:0]          tx_baud_max_cnt;
   logic [1:0]           tx_parity_sel;
   logic                 tx_stop_sel;
   logic [7:0]           tx_data;
   logic                 tx_send_en;
   logic                 tx_done;

   modport master (
      output req_valid, req_data, tx_done,
      input  req_ready, tx_baud_max_cnt, tx_parity_sel, tx_stop_sel, tx_data, tx_send_en
   );

   modport slave (
      input  req_valid, req_data, tx_done,
      output req_ready, tx_baud_max_cnt, tx_parity_sel, tx_stop_sel, tx_data, tx_send_en
   );
endinterface

// File: rtl/rr_arbiter_core.sv
// Combinational round-robin pick: first asserted request at or above the
// pointer, wrapping to the bottom of the vector when nothing is found above.
module rr_arbiter_core #(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grantIdx
);

   logic found;

   // Two passes (upper half from the pointer, then the wrapped lower half) give the circular search order.
   always_comb begin
      grant    = '0;
      grantIdx = '0;
      found    = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!found && req[j] && (j >= int'(ptr))) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            grantIdx = IDX_W'(j);
         end
      end
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!found && req[j] && (j < int'(ptr))) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            grantIdx = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares a single uart_tx between NUM_REQ byte sources. A round-robin winner
// is accepted in IDLE, its byte and the line configuration are frozen into the
// tx_* registers, send_en is pulsed once, and the block waits for done (or a
// timeout) followed by an optional idle gap before the next grant.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter  int NUM_REQ     = 4,
   parameter  int GAP_CYCLES  = 16,
   parameter  int TIMEOUT_CYC = 262144,
   localparam int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                  clock,
   input  logic                  reset,
   uart_tx_arbiter_if.slave      bus,
   input  logic [15:0]           cfg_baud_max_cnt,
   input  logic [1:0]            cfg_parity_sel,
   input  logic                  cfg_stop_sel,
   output logic                  busy,
   output logic [IDX_W-1:0]      grant_id,
   output logic                  timeout_err
);

   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
   localparam logic [31:0] GAP_LAST     = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;

   arb_state_t         state;
   arb_state_t         nextState;
   logic [31:0]        cycleCnt;
   logic [IDX_W-1:0]   rrPtr;
   logic [NUM_REQ-1:0] winGrant;
   logic [IDX_W-1:0]   winIdx;
   logic [7:0]         winByte;
   logic               anyReq;
   logic [NUM_REQ-1:0] reqReadyC;
   logic               sendEnC;
   logic               busyC;
   logic [7:0]         txData;
   logic [15:0]        txBaud;
   logic [1:0]         txParity;
   logic               txStop;
   logic [IDX_W-1:0]   grantIdReg;
   logic               timeoutErrReg;

   assign anyReq = |bus.req_valid;

   rr_arbiter_core #(
      .NUM_REQ (NUM_REQ)
   ) u_core (
      .req      (bus.req_valid),
      .ptr      (rrPtr),
      .grant    (winGrant),
      .grantIdx (winIdx)
   );

   // Select the winner's byte out of the packed request data.
   always_comb begin
      winByte = 8'h00;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (winGrant[k]) begin
            winByte = bus.req_data[8*k +: 8];
         end
      end
   end

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state and handshake outputs; ready is masked during reset so nothing is acked while held.
   always_comb begin
      nextState = state;
      reqReadyC = '0;
      sendEnC   = 1'b0;
      busyC     = (state != ST_IDLE);
      case (state)
         ST_IDLE: begin
            if (!reset) begin
               reqReadyC = winGrant;
            end
            if (anyReq) begin
               nextState = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            sendEnC   = 1'b1;
            nextState = ST_BUSY;
         end
         ST_BUSY: begin
            if (bus.tx_done) begin
               nextState = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            end else if (cycleCnt == TIMEOUT_LAST) begin
               nextState = ST_IDLE;
            end
         end
         ST_GAP: begin
            if (cycleCnt == GAP_LAST) begin
               nextState = ST_IDLE;
            end
         end
         default: begin
            nextState = ST_IDLE;
         end
      endcase
   end

   // Shared cycle counter: restarts on every state change, runs in BUSY (timeout) and GAP (spacing).
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cycleCnt <= 32'd0;
      end else if (nextState != state) begin
         cycleCnt <= 32'd0;
      end else if ((state == ST_BUSY) || (state == ST_GAP)) begin
         cycleCnt <= cycleCnt + 32'd1;
      end
   end

   // Frame registers: byte, owner and line config are captured only at the accept, so they hold across the frame.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         txData     <= 8'h00;
         txBaud     <= UART_BAUD_115200_AT_1M2;
         txParity   <= PARITY_NONE;
         txStop     <= 1'b0;
         grantIdReg <= '0;
         rrPtr      <= '0;
      end else if ((state == ST_IDLE) && anyReq) begin
         txData     <= winByte;
         txBaud     <= cfg_baud_max_cnt;
         txParity   <= cfg_parity_sel;
         txStop     <= cfg_stop_sel;
         grantIdReg <= winIdx;
         rrPtr      <= (winIdx == IDX_W'(NUM_REQ - 1)) ? '0 : winIdx + 1'b1;
      end
   end

   // Sticky hung-transmitter flag; a done arriving on the last allowed cycle still counts as success.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         timeoutErrReg <= 1'b0;
      end else if ((state == ST_BUSY) && !bus.tx_done && (cycleCnt == TIMEOUT_LAST)) begin
         timeoutErrReg <= 1'b1;
      end
   end

   assign bus.req_ready       = reqReadyC;
   assign bus.tx_send_en      = sendEnC;
   assign bus.tx_data         = txData;
   assign bus.tx_baud_max_cnt = txBaud;
   assign bus.tx_parity_sel   = txParity;
   assign bus.tx_stop_sel     = txStop;
   assign busy                = busyC;
   assign grant_id            = grantIdReg;
   assign timeout_err         = timeoutErrReg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus queues the expected frame for
// each request, a monitor pops and compares at every send_en pulse, and a
// behavioural transmitter answers each send_en with a done pulse.
module tb_uart_tx_arbiter;
   import uart_pkg::*;

   localparam int NUM_REQ     = 4;
   localparam int GAP_CYCLES  = 4;
   localparam int TIMEOUT_CYC = 64;
   localparam int DONE_DELAY  = 10;
   localparam int IDX_W       = 2;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic [7:0]       data;
      logic [15:0]      baud;
      logic [1:0]       par;
      logic             stop;
   } frame_t;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic [15:0]      cfgBaud;
   logic [1:0]       cfgParity;
   logic             cfgStop;
   logic             busy;
   logic [IDX_W-1:0] grantId;
   logic             timeoutErr;

   int     checks   = 0;
   int     errors   = 0;
   frame_t expQ[$];
   logic   hang     = 1'b0;
   int     epoch    = 0;
   logic   gapCheck = 1'b0;
   logic   doneSeen = 1'b0;

   uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

   uart_tx_arbiter #(
      .NUM_REQ     (NUM_REQ),
      .GAP_CYCLES  (GAP_CYCLES),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .bus              (bus),
      .cfg_baud_max_cnt (cfgBaud),
      .cfg_parity_sel   (cfgParity),
      .cfg_stop_sel     (cfgStop),
      .busy             (busy),
      .grant_id         (grantId),
      .timeout_err      (timeoutErr)
   );

   initial forever #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Raise requester idx with a byte and queue the frame it should produce under the current config.
   task automatic applyStimulus(input int idx, input logic [7:0] data);
      frame_t f;
      bus.req_data[8*idx +: 8] = data;
      bus.req_valid[idx]       = 1'b1;
      f.idx  = IDX_W'(idx);
      f.data = data;
      f.baud = cfgBaud;
      f.par  = cfgParity;
      f.stop = cfgStop;
      expQ.push_back(f);
   endtask

   task automatic syncDrive();
      @(posedge clock);
      #1;
   endtask

   task automatic waitQuiet(input int maxCyc);
      int k;
      for (k = 0; k < maxCyc; k++) begin
         @(negedge clock);
         if ((bus.req_valid == '0) && !busy && (expQ.size() == 0)) break;
      end
      if (k == maxCyc) begin
         checks++;
         errors++;
         $display("[TB] FAIL wait_quiet expired pending=%0d busy=%0b", expQ.size(), busy);
      end
   endtask

   task automatic waitPop(input int maxCyc);
      int k;
      for (k = 0; k < maxCyc; k++) begin
         @(negedge clock);
         if (expQ.size() == 0) break;
      end
      if (k == maxCyc) begin
         checks++;
         errors++;
         $display("[TB] FAIL wait_launch expired pending=%0d", expQ.size());
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_req_ready"}, bus.req_ready, 0);
      checkOutput({tag, "_send_en"}, bus.tx_send_en, 0);
      checkOutput({tag, "_tx_data"}, bus.tx_data, 0);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_grant_id"}, grantId, 0);
      checkOutput({tag, "_timeout_err"}, timeoutErr, 0);
      checkOutput({tag, "_baud"}, bus.tx_baud_max_cnt, 16'd10416);
      checkOutput({tag, "_parity"}, bus.tx_parity_sel, 0);
      checkOutput({tag, "_stop"}, bus.tx_stop_sel, 0);
   endtask

   // Requesters: drop valid just after the edge that captured their ack.
   initial begin : requesterDrop
      logic [NUM_REQ-1:0] ack;
      forever begin
         @(negedge clock);
         ack = bus.req_ready & bus.req_valid;
         @(posedge clock);
         #1;
         bus.req_valid = bus.req_valid & ~ack;
      end
   end

   // Behavioural uart_tx: done pulse DONE_DELAY edges after send_en, abandoned on reset or hang.
   initial begin : uartModel
      int ep;
      logic aborted;
      forever begin
         @(negedge clock);
         if (bus.tx_send_en && !reset && !hang) begin
            ep = epoch;
            aborted = 1'b0;
            for (int k = 0; k < DONE_DELAY; k++) begin
               @(posedge clock);
               if (ep != epoch) begin
                  aborted = 1'b1;
                  break;
               end
            end
            if (!aborted) begin
               #1 bus.tx_done = 1'b1;
               @(posedge clock);
               #1 bus.tx_done = 1'b0;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on each send_en and checks handshake timing and frame hold.
   initial begin : monitor
      frame_t exp;
      frame_t cur;
      logic frameActive = 1'b0;
      logic prevAck     = 1'b0;
      logic prevSend    = 1'b0;
      int   cyc         = 0;
      int   doneCyc     = 0;
      forever begin
         @(negedge clock);
         cyc++;
         if (reset) begin
            frameActive = 1'b0;
            prevAck     = 1'b0;
            prevSend    = 1'b0;
         end else begin
            if (prevAck) checkOutput("ack_then_launch", {bus.tx_send_en, |bus.req_ready}, 2'b10);
            if (bus.tx_send_en) begin
               checkOutput("send_en_width", prevSend, 0);
               if (expQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected_frame data=%0h grant=%0d", bus.tx_data, grantId);
               end else begin
                  exp = expQ.pop_front();
                  checkOutput("grant_id", grantId, exp.idx);
                  checkOutput("tx_data", bus.tx_data, exp.data);
                  checkOutput("tx_baud", bus.tx_baud_max_cnt, exp.baud);
                  checkOutput("tx_parity", bus.tx_parity_sel, exp.par);
                  checkOutput("tx_stop", bus.tx_stop_sel, exp.stop);
                  cur = exp;
                  frameActive = 1'b1;
               end
            end else if (busy && frameActive) begin
               checkOutput("tx_hold", {bus.tx_data, bus.tx_baud_max_cnt, bus.tx_parity_sel, bus.tx_stop_sel},
                           {cur.data, cur.baud, cur.par, cur.stop});
            end
            if (!busy) frameActive = 1'b0;
            if (|bus.req_ready) begin
               checkOutput("ready_onehot", {$onehot(bus.req_ready), ((bus.req_ready & ~bus.req_valid) == '0)}, 2'b11);
               if (gapCheck && doneSeen) begin
                  checkOutput("gap_cycles", 64'(cyc - doneCyc - 1), GAP_CYCLES);
                  doneSeen = 1'b0;
               end
            end
            if (bus.tx_done) begin
               doneCyc  = cyc;
               doneSeen = 1'b1;
            end
            prevAck  = |bus.req_ready;
            prevSend = bus.tx_send_en;
         end
      end
   end

   initial begin : mainSeq
      int busyCnt;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.tx_done   = 1'b0;
      cfgBaud   = UART_BAUD_115200_AT_1M2;
      cfgParity = PARITY_NONE;
      cfgStop   = 1'b0;
      #2 reset = 1'b1;
      repeat (2) @(negedge clock);
      checkResetValues("reset");
      syncDrive();
      reset = 1'b0;

      // All four requesters at once from pointer 0: frames 0,1,2,3 with exact gaps.
      $display("[TB] all requesters, round-robin order and gap");
      cfgBaud   = 16'd100;
      cfgParity = PARITY_ODD;
      cfgStop   = 1'b0;
      doneSeen  = 1'b0;
      gapCheck  = 1'b1;
      syncDrive();
      applyStimulus(0, 8'h41);
      applyStimulus(1, 8'h42);
      applyStimulus(2, 8'h43);
      applyStimulus(3, 8'h44);
      waitQuiet(400);
      gapCheck = 1'b0;

      // Single request on requester 2.
      $display("[TB] single request on requester 2");
      cfgBaud   = 16'd10416;
      cfgParity = PARITY_EVEN;
      cfgStop   = 1'b1;
      syncDrive();
      applyStimulus(2, 8'h43);
      waitQuiet(100);

      // Requester 3 served, then 0 and 3 together: pointer wraps so 0 goes first.
      $display("[TB] round-robin wrap");
      syncDrive();
      applyStimulus(3, 8'h33);
      waitQuiet(100);
      syncDrive();
      applyStimulus(0, 8'h30);
      applyStimulus(3, 8'h3a);
      waitQuiet(200);

      // Config change mid-frame only takes effect on the following frame.
      $display("[TB] config change during busy");
      cfgBaud   = 16'd10416;
      cfgParity = PARITY_NONE;
      cfgStop   = 1'b0;
      syncDrive();
      applyStimulus(1, 8'h4a);
      waitPop(50);
      syncDrive();
      cfgBaud   = 16'd5207;
      cfgParity = PARITY_ODD;
      cfgStop   = 1'b1;
      @(negedge clock);
      checkOutput("cfg_mid_busy", busy, 1);
      checkOutput("cfg_mid_baud", bus.tx_baud_max_cnt, 16'd10416);
      syncDrive();
      applyStimulus(1, 8'h4b);
      waitQuiet(200);

      // Hung transmitter: 1 LAUNCH + TIMEOUT_CYC BUSY cycles, then sticky error and back to IDLE.
      $display("[TB] done timeout");
      hang = 1'b1;
      syncDrive();
      applyStimulus(0, 8'h55);
      busyCnt = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clock);
         if (busy) busyCnt++;
         else if (busyCnt > 0) break;
      end
      checkOutput("timeout_busy_cycles", busyCnt, TIMEOUT_CYC + 1);
      checkOutput("timeout_err_set", timeoutErr, 1);
      checkOutput("timeout_idle", busy, 0);
      hang = 1'b0;
      syncDrive();
      applyStimulus(1, 8'h66);
      waitQuiet(100);
      checkOutput("timeout_err_sticky", timeoutErr, 1);

      // Reset mid-frame with requesters 1 and 3 pending: immediate reset values, then 1 before 3.
      $display("[TB] reset during busy");
      syncDrive();
      applyStimulus(2, 8'h62);
      waitPop(50);
      repeat (3) @(posedge clock);
      #1;
      applyStimulus(1, 8'h51);
      applyStimulus(3, 8'h53);
      syncDrive();
      reset = 1'b1;
      epoch++;
      #1;
      checkResetValues("midreset");
      syncDrive();
      reset = 1'b0;
      waitQuiet(200);

      checkOutput("scoreboard_drained", expQ.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
